// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-bus access path: access sizes,
// FSM states, byte-enable patterns and the alignment rule.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Size 11 falls into the word case.
    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/response signals between the MEM stage and memory.
interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata, dbus_err
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata, dbus_err
    );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends it.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: checks alignment, issues one registered data-bus
// transfer, stalls the pipe until it completes, and handles error/timeout/flush.
module mem_access
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_memread,
    input  logic        M_memwrite,
    input  logic [1:0]  M_size,
    input  logic        M_unsigned,
    input  logic [31:0] M_alu_out,
    input  logic [31:0] M_wdata,
    input  logic        M_flush,
    input  logic        WB_stall,
    output logic        M_stall,
    output logic [31:0] M_readdata,
    output logic        M_adel,
    output logic        M_ades,
    output logic        M_buserr,
    mem_access_if.master dbus
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_e             state, state_d;
    logic               req_q, we_q, kill_q;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic [3:0]         be_q;
    logic               buserr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               aligned, issue, xfer_end, ok_load, fail, killed, timeout;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d, ld_data;

    assign aligned = addr_aligned(M_size, M_alu_out[1:0]);
    assign killed  = kill_q | M_flush;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        case (M_size)
            SZ_BYTE: begin
                be_d    = BE_BYTE << M_alu_out[1:0];
                wdata_d = {4{M_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_d    = BE_HALF << {M_alu_out[1], 1'b0};
                wdata_d = {2{M_wdata[15:0]}};
            end
            default: begin
                be_d    = BE_WORD;
                wdata_d = M_wdata;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata       (dbus.dbus_rdata),
        .off         (M_alu_out[1:0]),
        .size        (M_size),
        .is_unsigned (M_unsigned),
        .data        (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        xfer_end = 1'b0;
        ok_load  = 1'b0;
        fail     = 1'b0;
        M_stall  = 1'b0;
        M_adel   = 1'b0;
        M_ades   = 1'b0;
        case (state)
            IDLE: begin
                if ((M_memread | M_memwrite) & ~M_flush) begin
                    if (aligned) begin
                        issue   = 1'b1;
                        M_stall = 1'b1;
                        state_d = WAIT;
                    end else begin
                        M_adel = M_memread;
                        M_ades = M_memwrite & ~M_memread;
                    end
                end
            end
            WAIT: begin
                M_stall = 1'b1;
                if (dbus.dbus_ack | timeout) begin
                    xfer_end = 1'b1;
                    // A killed instruction drains silently back to IDLE.
                    if (killed) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        fail    = ~dbus.dbus_ack | dbus.dbus_err;
                        ok_load = dbus.dbus_ack & ~dbus.dbus_err & ~we_q;
                    end
                end
            end
            DONE: begin
                M_stall = WB_stall;
                if (!WB_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
            kill_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            buserr_q <= fail;
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= M_memwrite;
                addr_q  <= {M_alu_out[31:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                kill_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (state == WAIT) begin
                if (xfer_end) begin
                    req_q  <= 1'b0;
                    kill_q <= 1'b0;
                end else begin
                    kill_q <= killed;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
            end
            if (fail)         rdata_q <= '0;
            else if (ok_load) rdata_q <= ld_data;
        end
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_be    = be_q;
    assign dbus.dbus_wdata = wdata_q;
    assign M_readdata      = rdata_q;
    assign M_buserr        = buserr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, alignment errors, bus error,
// timeout, flush, WB back-pressure and reset during a transfer.
module tb_mem_access;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_memread, M_memwrite, M_unsigned, M_flush, WB_stall;
    logic [1:0]  M_size;
    logic [31:0] M_alu_out, M_wdata, M_readdata;
    logic        M_stall, M_adel, M_ades, M_buserr;

    mem_access_if bus();

    mem_access #(.TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_memread  (M_memread),
        .M_memwrite (M_memwrite),
        .M_size     (M_size),
        .M_unsigned (M_unsigned),
        .M_alu_out  (M_alu_out),
        .M_wdata    (M_wdata),
        .M_flush    (M_flush),
        .WB_stall   (WB_stall),
        .M_stall    (M_stall),
        .M_readdata (M_readdata),
        .M_adel     (M_adel),
        .M_ades     (M_ades),
        .M_buserr   (M_buserr),
        .dbus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one access; ack_at = WAIT cycle (1-based) carrying ack, 0 = never.
    task automatic xfer(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic err, input int ack_at,
                        output int stalls, output logic [31:0] rq, output logic berr,
                        output logic req_done, output logic we_o, output logic [31:0] addr_o,
                        output logic [3:0] be_o, output logic [31:0] wd_o);
        logic done;
        @(negedge clk);
        M_memread = rd; M_memwrite = wr; M_size = sz; M_unsigned = uns;
        M_alu_out = a; M_wdata = wd; bus.dbus_ack = 1'b0;
        #1;
        stalls = M_stall ? 1 : 0;
        done = 1'b0;
        rq = '0; berr = 1'b0; req_done = 1'b1;
        we_o = 1'b0; addr_o = '0; be_o = '0; wd_o = '0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            bus.dbus_ack   = (c == ack_at);
            bus.dbus_rdata = rdat;
            bus.dbus_err   = err;
            #1;
            if (c == 1) begin
                we_o = bus.dbus_we; addr_o = bus.dbus_addr;
                be_o = bus.dbus_be; wd_o = bus.dbus_wdata;
            end
            if (M_stall) stalls++;
            else begin
                done = 1'b1;
                rq = M_readdata; berr = M_buserr; req_done = bus.dbus_req;
            end
        end
        check("xfer_reached_done", {31'd0, done}, 32'd1);
        M_memread = 1'b0; M_memwrite = 1'b0;
        bus.dbus_ack = 1'b0; bus.dbus_err = 1'b0;
    endtask

    int          st;
    logic [31:0] rq, ao, wo;
    logic        be_err, rqd, weo;
    logic [3:0]  beo;

    initial begin
        rst_n = 1'b0;
        M_memread = 0; M_memwrite = 0; M_size = SZ_WORD; M_unsigned = 0;
        M_alu_out = '0; M_wdata = '0; M_flush = 0; WB_stall = 0;
        bus.dbus_ack = 0; bus.dbus_rdata = '0; bus.dbus_err = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'd0, bus.dbus_req}, 32'd0);
        check("rst_we", {31'd0, bus.dbus_we}, 32'd0);
        check("rst_addr", bus.dbus_addr, 32'd0);
        check("rst_be", {28'd0, bus.dbus_be}, 32'd0);
        check("rst_wdata", bus.dbus_wdata, 32'd0);
        check("rst_readdata", M_readdata, 32'd0);
        check("rst_buserr", {31'd0, M_buserr}, 32'd0);
        check("rst_stall", {31'd0, M_stall}, 32'd0);
        rst_n = 1'b1;

        // Misaligned word load and half store
        @(negedge clk);
        M_memread = 1; M_size = SZ_WORD; M_alu_out = 32'h0000_3001;
        #1;
        check("mis_adel", {31'd0, M_adel}, 32'd1);
        check("mis_ades0", {31'd0, M_ades}, 32'd0);
        check("mis_stall", {31'd0, M_stall}, 32'd0);
        @(negedge clk); #1;
        check("mis_noreq", {31'd0, bus.dbus_req}, 32'd0);
        M_memread = 0; M_memwrite = 1; M_size = SZ_HALF; M_alu_out = 32'h0000_2003;
        #1;
        check("mis_ades", {31'd0, M_ades}, 32'd1);
        check("mis_adel0", {31'd0, M_adel}, 32'd0);
        M_memwrite = 0;

        // Signed byte load, lane 3, ack on third WAIT cycle
        xfer(1, 0, SZ_BYTE, 0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 3,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("lb_stalls", st, 32'd4);
        check("lb_data", rq, 32'hFFFF_FF80);
        check("lb_addr", ao, 32'h0000_1000);
        check("lb_we", {31'd0, weo}, 32'd0);
        check("lb_req_low", {31'd0, rqd}, 32'd0);
        check("lb_buserr", {31'd0, be_err}, 32'd0);

        xfer(1, 0, SZ_BYTE, 1, 32'h0000_1001, 32'd0, 32'h80FF_1234, 0, 1,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("lbu_stalls", st, 32'd2);
        check("lbu_data", rq, 32'h0000_0012);

        xfer(1, 0, SZ_HALF, 0, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0, 1,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("lh_data", rq, 32'hFFFF_80FF);

        xfer(1, 0, SZ_WORD, 0, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF, 0, 2,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("lw_data", rq, 32'hDEAD_BEEF);

        // Flush in WAIT: transfer still acked, FSM returns straight to IDLE
        @(negedge clk);
        M_memread = 1; M_size = SZ_WORD; M_unsigned = 0; M_alu_out = 32'h0000_5000;
        #1;
        check("fl_stall_issue", {31'd0, M_stall}, 32'd1);
        @(negedge clk); M_flush = 1; #1;
        check("fl_stall_w1", {31'd0, M_stall}, 32'd1);
        @(negedge clk); M_flush = 0; M_memread = 0; #1;
        check("fl_stall_w2", {31'd0, M_stall}, 32'd1);
        @(negedge clk); bus.dbus_ack = 1; bus.dbus_rdata = 32'hCAFE_F00D; #1;
        @(negedge clk);
        bus.dbus_ack = 0;
        M_memread = 1; M_size = SZ_WORD; M_alu_out = 32'h0000_3001;
        #1;
        check("fl_idle_adel", {31'd0, M_adel}, 32'd1);
        check("fl_stall", {31'd0, M_stall}, 32'd0);
        check("fl_buserr", {31'd0, M_buserr}, 32'd0);
        check("fl_data_kept", M_readdata, 32'hDEAD_BEEF);
        check("fl_req_low", {31'd0, bus.dbus_req}, 32'd0);
        M_memread = 0;

        // Stores
        xfer(0, 1, SZ_HALF, 0, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0, 1,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("sh_be", {28'd0, beo}, 32'h0000_000C);
        check("sh_wdata", wo, 32'hABCD_ABCD);
        check("sh_addr", ao, 32'h0000_2000);
        check("sh_we", {31'd0, weo}, 32'd1);
        check("sh_data_kept", rq, 32'hDEAD_BEEF);

        xfer(0, 1, SZ_BYTE, 0, 32'h0000_2001, 32'h0000_005A, 32'd0, 0, 1,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("sb_be", {28'd0, beo}, 32'h0000_0002);
        check("sb_wdata", wo, 32'h5A5A_5A5A);

        // Bus error on ack
        xfer(1, 0, SZ_WORD, 0, 32'h0000_6000, 32'd0, 32'h1111_1111, 1, 2,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("err_stalls", st, 32'd3);
        check("err_buserr", {31'd0, be_err}, 32'd1);
        check("err_data", rq, 32'd0);
        @(negedge clk); #1;
        check("err_pulse_end", {31'd0, M_buserr}, 32'd0);

        // WB_stall holds DONE
        @(negedge clk);
        M_memread = 1; M_size = SZ_WORD; M_alu_out = 32'h0000_4000; WB_stall = 1;
        @(negedge clk); bus.dbus_ack = 1; bus.dbus_rdata = 32'h1234_5678; #1;
        @(negedge clk); bus.dbus_ack = 0; #1;
        check("wbs_stall1", {31'd0, M_stall}, 32'd1);
        check("wbs_data1", M_readdata, 32'h1234_5678);
        @(negedge clk); #1;
        check("wbs_stall2", {31'd0, M_stall}, 32'd1);
        check("wbs_data2", M_readdata, 32'h1234_5678);
        WB_stall = 0; #1;
        check("wbs_release", {31'd0, M_stall}, 32'd0);
        @(negedge clk); M_memread = 0; #1;

        // Timeout: no ack at all
        xfer(1, 0, SZ_WORD, 0, 32'h0000_8000, 32'd0, 32'd0, 0, 0,
             st, rq, be_err, rqd, weo, ao, beo, wo);
        check("to_stalls", st, 32'd65);
        check("to_buserr", {31'd0, be_err}, 32'd1);
        check("to_data", rq, 32'd0);
        check("to_req_low", {31'd0, rqd}, 32'd0);
        @(negedge clk); #1;
        check("to_pulse_end", {31'd0, M_buserr}, 32'd0);
        check("to_idle_stall", {31'd0, M_stall}, 32'd0);

        // Reset mid-WAIT, then a stray ack
        @(negedge clk);
        M_memread = 1; M_size = SZ_WORD; M_alu_out = 32'h0000_7000;
        @(negedge clk); #1;
        check("rw_req", {31'd0, bus.dbus_req}, 32'd1);
        rst_n = 0; M_memread = 0; #1;
        check("rw_req_rst", {31'd0, bus.dbus_req}, 32'd0);
        check("rw_addr_rst", bus.dbus_addr, 32'd0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); bus.dbus_ack = 1; bus.dbus_rdata = 32'hFFFF_FFFF; #1;
        check("rw_stall", {31'd0, M_stall}, 32'd0);
        @(negedge clk); bus.dbus_ack = 0; #1;
        check("rw_data", M_readdata, 32'd0);
        check("rw_buserr", {31'd0, M_buserr}, 32'd0);
        check("rw_req_idle", {31'd0, bus.dbus_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before a bus timeout.
REQ-002 SHALL have ports:
  - clk  in  1  single clock; all state on posedge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - M_memread  in  1  load in MEM stage.
  - M_memwrite  in  1  store in MEM stage.
  - M_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
  - M_unsigned  in  1  zero-extend load (else sign-extend).
  - M_alu_out  in  32  effective address.
  - M_wdata  in  32  store data, right-justified.
  - M_flush  in  1  kill current MEM instruction.
  - WB_stall  in  1  downstream MEM/WB register holding.
  - M_stall  out  1  hold MEM stage and upstream.
  - M_readdata  out  32  aligned, extended load result.
  - M_adel  out  1  load address error.
  - M_ades  out  1  store address error.
  - M_buserr  out  1  bus error/timeout, one-cycle pulse.
  - dbus_req  out  1  registered request.
  - dbus_we  out  1  write.
  - dbus_addr  out  32  word address, [1:0]=00.
  - dbus_be  out  4  byte enables, lane0 = bits 7:0.
  - dbus_wdata  out  32  lane-replicated store data.
  - dbus_ack  in  1  transfer complete, rdata valid.
  - dbus_rdata  in  32  read data.
  - dbus_err  in  1  transfer failed, valid with ack.

Function
REQ-003 SHALL use FSM states IDLE, WAIT, DONE.
REQ-004 Access = (M_memread|M_memwrite) & ~M_flush & aligned; aligned: byte always, half addr[0]=0, word addr[1:0]=00.
REQ-005 In IDLE, misaligned access SHALL assert M_adel (read) or M_ades (write) combinationally that cycle, issue no request, keep M_stall 0.
REQ-006 In IDLE, a valid access SHALL register dbus_req=1, dbus_we, dbus_addr, dbus_be, dbus_wdata and move to WAIT next cycle.
REQ-007 M_stall SHALL be 1 in IDLE-with-valid-access, throughout WAIT, and 0 in DONE unless WB_stall.
REQ-008 In WAIT, dbus_* outputs SHALL hold stable until dbus_ack; on the ack cycle, dbus_req SHALL deassert next edge.
REQ-009 On dbus_ack with dbus_err=0: load data SHALL be registered into M_readdata; state becomes DONE.
REQ-010 On dbus_ack with dbus_err=1, or WAIT counter reaching TIMEOUT: M_buserr SHALL pulse one cycle, M_readdata SHALL be 0, state becomes DONE; timeout drops dbus_req.
REQ-011 In DONE, state SHALL stay while WB_stall=1, then return to IDLE; DONE SHALL ignore M_memread/M_memwrite (same instruction).
REQ-012 M_flush in WAIT SHALL set a kill flag; the transfer completes on the bus; on ack the FSM SHALL go to IDLE (not DONE) with no M_buserr and M_readdata unchanged.
REQ-013 Load extract, little-endian: byte = rdata lane addr[1:0]; half = lane pair addr[1]; word unchanged; extend per M_unsigned to 32 bits.
REQ-014 Store: be byte = 0001<<addr[1:0], half = 0011<<(2*addr[1]), word = 1111; wdata byte replicated x4, half x2.
REQ-015 WAIT counter: 8 bits min, cleared on entry to WAIT, saturating.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, dbus_req 0, dbus_we 0, dbus_addr/be/wdata 0, M_readdata 0, M_buserr 0, kill flag 0, counter 0.
REQ-017 rst_n low mid-WAIT SHALL abandon the transfer; a late dbus_ack after reset is ignored in IDLE.

Structure
REQ-018 Shared package mips_mem_pkg SHALL hold size encodings, FSM state type and BE constants.
REQ-019 Load extraction/extension SHALL be sub-module mem_load_align (combinational).

Verification
REQ-020 Load byte addr 0x1003, M_unsigned=0, rdata 0x80FF_1234, ack after 3 cycles -> M_stall 4 cycles, M_readdata 0xFFFF_FF80.
REQ-021 Store half addr 0x2002, M_wdata 0x0000_ABCD -> dbus_be 1100, dbus_wdata 0xABCD_ABCD, dbus_addr 0x2000, we=1.
REQ-022 Load word addr 0x3001 -> M_adel=1 same cycle, dbus_req stays 0, M_stall 0.
REQ-023 No ack for TIMEOUT=64 cycles -> M_buserr one-cycle pulse, M_readdata 0, dbus_req low, DONE then IDLE.
REQ-024 M_flush during WAIT, ack 2 cycles later -> return IDLE, no DONE cycle, M_buserr 0; WB_stall=1 in DONE holds M_stall 1 and M_readdata.
